dot_product_engine: RTL and testbench
=====================================

// Module: dot_product_engine
// PURPOSE
//   Parametrised multiply-accumulate engine: computes the dot product of two streamed vectors, VEC_LEN elements each.
//   Operands arrive as one (A,B) pair per accepted beat over a VALID/READY handshake, so the upstream vector memory may stall.
//   Supports signed/unsigned operands and a configurable accumulator width with overflow reporting.
//   Sits between the vector register files and the result/display path.
// PARAMETERS
//   DATA_W   8                               operand width (bits), >=2
//   VEC_LEN  8                               elements per dot product, >=1
//   SIGNED   0                               0: unsigned operands; 1: two's-complement operands and result
//   ACC_W    2*DATA_W+$clog2(VEC_LEN+1)      accumulator/result width, >=2*DATA_W
// PORTS
//   CLK       in   1       clock, all logic on posedge
//   RST       in   1       synchronous reset, active-high
//   START     in   1       request new computation; honoured only in IDLE
//   IN_VALID  in   1       dataA/dataB valid this cycle
//   IN_READY  out  1       engine accepts a beat this cycle
//   dataA     in   DATA_W  element of vector A
//   dataB     in   DATA_W  element of vector B
//   result    out  ACC_W   dot product of last completed operation
//   DONE      out  1       one-cycle pulse: result updated
//   BUSY      out  1       operation in progress
//   OVF       out  1       last completed operation overflowed ACC_W
// BEHAVIOUR
//   - Reset (RST=1 at posedge): state=IDLE; result=0, DONE=0, BUSY=0, OVF=0, IN_READY=0; acc, cnt, ovf_acc cleared.
//   - RST wins over every other input, including mid-operation. Partial sums are discarded. No DONE is produced.
//   - States:
//       IDLE  --START-->  ACCUM
//       ACCUM --last beat accepted-->  IDLE
//   - IDLE + START: acc=0, cnt=0, ovf_acc=0, BUSY=1 from the next cycle. IN_VALID is ignored in IDLE.
//   - IN_READY = (state==ACCUM). A beat is accepted when IN_VALID && IN_READY.
//     Cycles without a beat hold acc and cnt (bubbles allowed, no timeout).
//   - Per beat: prod = dataA*dataB, full 2*DATA_W width, signedness per SIGNED.
//     prod is sign- or zero-extended to ACC_W+1 bits, then sum = acc + prod.
//     Overflow = sum is outside the ACC_W range (signed or unsigned per SIGNED).
//     On overflow ovf_acc is set (sticky) and acc takes the value given under CONFIGURATION.
//   - Beat with cnt==VEC_LEN-1 (the last beat): on that same edge
//       result <= new acc value
//       OVF <= ovf_acc | this beat's overflow
//       DONE <= 1, BUSY <= 0, state <= IDLE
//   - Latency: DONE/result are visible in the cycle after the last accepted beat.
//     With no bubbles, the Nth beat lands N cycles after the START edge.
//   - DONE is high for exactly 1 cycle. result and OVF hold until the next completion or RST.
//   - START while BUSY: ignored, no effect on the running operation.
//     START in the DONE cycle (state already IDLE): accepted. Back-to-back operations are legal.
//   - VEC_LEN==1: the first accepted beat completes the operation.
//     cnt width is max(1,$clog2(VEC_LEN)), with no wrap beyond VEC_LEN-1.
//   - Unsigned default ACC_W never overflows. OVF is only reachable with an overridden, smaller ACC_W.
// CONFIGURATION
//   DOTP_SAT_EN defined:
//     on overflow acc clamps to the ACC_W max (positive overflow) or min (negative; SIGNED=1 only).
//     Subsequent beats continue from the clamped value. OVF is still reported.
//   DOTP_SAT_EN undefined:
//     acc wraps modulo 2^ACC_W. OVF is still reported.
//   The macro does not affect ports, latency or handshake.
// TESTING
//   1. Defaults; START, then 8 beats a=b=255 with IN_VALID=1 continuous
//      -> result=520200, OVF=0, DONE pulse in the cycle after beat 8.
//   2. Defaults; a=1..8, b=2, IN_VALID alternating 0/1
//      -> result=72, DONE only after the 8th accepted beat (16 cycles), IN_READY=1 throughout ACCUM.
//   3. SIGNED=1; 8 beats a=-128 (8'h80), b=127
//      -> result=-130048 (sign-extended in ACC_W), OVF=0.
//   4. ACC_W=16; 8 beats a=b=255
//      -> without DOTP_SAT_EN: result=61448, OVF=1
//      -> with DOTP_SAT_EN: result=65535, OVF=1
//   5. RST pulsed after 3 beats
//      -> next cycle all outputs 0, IN_READY=0
//      -> new START plus 8 beats a=b=1 gives result=8 with no residue.
//   6. START asserted during ACCUM: ignored, result unchanged.
//      START in the DONE cycle: a new op starts, and 8 beats a=2,b=3 give result=48.

Source files
------------

// File: rtl/dot_product_engine.sv
// Streaming multiply-accumulate: dot product of two VEC_LEN-element vectors fed one (A,B) pair per beat.
// Define DOTP_SAT_EN to clamp the accumulator on overflow; the default build wraps modulo 2^ACC_W.
module dot_product_engine #(
    parameter int DATA_W  = 8,
    parameter int VEC_LEN = 8,
    parameter int SIGNED  = 0,
    parameter int ACC_W   = 2*DATA_W + $clog2(VEC_LEN+1)
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              START,
    input  logic              IN_VALID,
    output logic              IN_READY,
    input  logic [DATA_W-1:0] dataA,
    input  logic [DATA_W-1:0] dataB,
    output logic [ACC_W-1:0]  result,
    output logic              DONE,
    output logic              BUSY,
    output logic              OVF
);

    localparam int CNT_W = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(VEC_LEN-1);

    typedef enum logic {IDLE, ACCUM} state_e;

    state_e             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ovf_acc_q, ovf_acc_d;
    logic [ACC_W-1:0]   result_q, result_d;
    logic               done_q, done_d;
    logic               busy_q, busy_d;
    logic               ovf_q, ovf_d;

    logic                a_msb, b_msb, acc_msb;
    logic signed [ACC_W:0] a_x, b_x, prod, acc_x, sum;
    logic                beat_ovf;
    logic [ACC_W-1:0]    acc_next;

    // One guard bit above ACC_W makes the sum exact, so overflow is a simple range test.
    always_comb begin
        a_msb    = (SIGNED != 0) && dataA[DATA_W-1];
        b_msb    = (SIGNED != 0) && dataB[DATA_W-1];
        acc_msb  = (SIGNED != 0) && acc_q[ACC_W-1];
        a_x      = {{(ACC_W+1-DATA_W){a_msb}}, dataA};
        b_x      = {{(ACC_W+1-DATA_W){b_msb}}, dataB};
        acc_x    = {acc_msb, acc_q};
        prod     = a_x * b_x;
        sum      = acc_x + prod;
        if (SIGNED != 0) beat_ovf = sum[ACC_W] ^ sum[ACC_W-1];
        else             beat_ovf = sum[ACC_W];
`ifdef DOTP_SAT_EN
        if (!beat_ovf)          acc_next = sum[ACC_W-1:0];
        else if (SIGNED == 0)   acc_next = '1;
        else if (sum[ACC_W])    acc_next = {1'b1, {(ACC_W-1){1'b0}}};
        else                    acc_next = {1'b0, {(ACC_W-1){1'b1}}};
`else
        acc_next = sum[ACC_W-1:0];
`endif
    end

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        ovf_acc_d = ovf_acc_q;
        result_d  = result_q;
        done_d    = 1'b0;
        busy_d    = busy_q;
        ovf_d     = ovf_q;
        case (state_q)
            IDLE: begin
                if (START) begin
                    state_d   = ACCUM;
                    acc_d     = '0;
                    cnt_d     = '0;
                    ovf_acc_d = 1'b0;
                    busy_d    = 1'b1;
                end
            end
            ACCUM: begin
                if (IN_VALID) begin
                    acc_d     = acc_next;
                    ovf_acc_d = ovf_acc_q | beat_ovf;
                    if (cnt_q == CNT_LAST) begin
                        result_d = acc_next;
                        ovf_d    = ovf_acc_q | beat_ovf;
                        done_d   = 1'b1;
                        busy_d   = 1'b0;
                        state_d  = IDLE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= IDLE;
            acc_q     <= '0;
            cnt_q     <= '0;
            ovf_acc_q <= 1'b0;
            result_q  <= '0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            ovf_acc_q <= ovf_acc_d;
            result_q  <= result_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
            ovf_q     <= ovf_d;
        end
    end

    assign IN_READY = (state_q == ACCUM);
    assign result   = result_q;
    assign DONE     = done_q;
    assign BUSY     = busy_q;
    assign OVF      = ovf_q;

endmodule

// File: tb/tb_dot_product_engine.sv
// Drives three engine configurations (default, SIGNED=1, ACC_W=16) in lockstep from shared stimulus;
// a scoreboard queue holds reference results computed with wide integer arithmetic.
module tb_dot_product_engine;

`ifdef DOTP_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst, start, in_valid;
    logic [7:0]  a, b;
    logic [2:0]  rdy, done, busy, ovf;
    logic [19:0] res_def, res_sgn;
    logic [15:0] res_a16;

    int checks = 0;
    int failures = 0;

    typedef struct {
        longint r0, r1, r2;
        bit     o0, o1, o2;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    dot_product_engine u_def (
        .CLK(clk), .RST(rst), .START(start), .IN_VALID(in_valid), .IN_READY(rdy[0]),
        .dataA(a), .dataB(b), .result(res_def), .DONE(done[0]), .BUSY(busy[0]), .OVF(ovf[0])
    );
    dot_product_engine #(.SIGNED(1)) u_sgn (
        .CLK(clk), .RST(rst), .START(start), .IN_VALID(in_valid), .IN_READY(rdy[1]),
        .dataA(a), .dataB(b), .result(res_sgn), .DONE(done[1]), .BUSY(busy[1]), .OVF(ovf[1])
    );
    dot_product_engine #(.ACC_W(16)) u_a16 (
        .CLK(clk), .RST(rst), .START(start), .IN_VALID(in_valid), .IN_READY(rdy[2]),
        .dataA(a), .dataB(b), .result(res_a16), .DONE(done[2]), .BUSY(busy[2]), .OVF(ovf[2])
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic void model(input logic [7:0] va[8], input logic [7:0] vb[8],
                                  input bit sgn, input int w, output longint r, output bit o);
        longint acc, p, mx, mn, span;
        acc  = 0;
        o    = 1'b0;
        span = longint'(1) <<< w;
        mx   = sgn ? (span / 2) - 1 : span - 1;
        mn   = sgn ? -(span / 2) : 0;
        for (int i = 0; i < 8; i++) begin
            if (sgn) p = longint'($signed(va[i])) * longint'($signed(vb[i]));
            else     p = longint'(va[i]) * longint'(vb[i]);
            acc += p;
            if (acc > mx || acc < mn) begin
                o = 1'b1;
                if (SAT) acc = (acc > mx) ? mx : mn;
                else begin
                    acc = acc & (span - 1);
                    if (acc > mx) acc -= span;
                end
            end
        end
        r = acc;
    endfunction

    // Scoreboard consumer: every DONE must match the oldest pending expectation.
    always @(negedge clk) begin
        if (done !== 3'b000) begin
            if (sb.size() == 0) chk("spurious_done", {61'd0, done}, 64'd0);
            else begin
                exp_t e;
                e = sb.pop_front();
                chk("done_sync", {61'd0, done}, 64'd7);
                chk("res_def", {44'd0, res_def}, {44'd0, 20'(e.r0)});
                chk("res_sgn", {44'd0, res_sgn}, {44'd0, 20'(e.r1)});
                chk("res_a16", {48'd0, res_a16}, {48'd0, 16'(e.r2)});
                chk("ovf_def", {63'd0, ovf[0]}, {63'd0, e.o0});
                chk("ovf_sgn", {63'd0, ovf[1]}, {63'd0, e.o1});
                chk("ovf_a16", {63'd0, ovf[2]}, {63'd0, e.o2});
            end
        end
    end

    // Called #1 after a posedge; pulses START across the next edge.
    task automatic begin_op(input logic [7:0] va[8], input logic [7:0] vb[8], input bit push);
        exp_t e;
        if (push) begin
            model(va, vb, 1'b0, 20, e.r0, e.o0);
            model(va, vb, 1'b1, 20, e.r1, e.o1);
            model(va, vb, 1'b0, 16, e.r2, e.o2);
            sb.push_back(e);
        end
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("busy_after_start", {61'd0, busy}, 64'd7);
        chk("rdy_after_start", {61'd0, rdy}, 64'd7);
    endtask

    task automatic feed(input logic [7:0] va[8], input logic [7:0] vb[8],
                        input int nb, input bit bub, input bit start_mid);
        int i = 0;
        int cyc = 0;
        while (i < nb && cyc < 64) begin
            in_valid = bub ? (cyc % 2 == 1) : 1'b1;
            a        = va[i];
            b        = vb[i];
            start    = start_mid && (i == 3);
            @(negedge clk);
            chk("rdy_accum", {61'd0, rdy}, 64'd7);
            chk("no_early_done", {61'd0, done}, 64'd0);
            @(posedge clk);
            if (in_valid) i++;
            #1;
            cyc++;
        end
        in_valid = 1'b0;
        start    = 1'b0;
        if (i < nb) chk("beat_timeout", 64'(i), 64'(nb));
        if (bub && nb == 8) chk("bubble_cycles", 64'(cyc), 64'd16);
    endtask

    task automatic post_done();
        chk("done_hi", {61'd0, done}, 64'd7);
        chk("busy_lo", {61'd0, busy}, 64'd0);
        @(posedge clk); #1;
        chk("done_one_cycle", {61'd0, done}, 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] va[8];
        logic [7:0] vb[8];
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; a = '0; b = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_res_def", {44'd0, res_def}, 64'd0);
        chk("rst_res_a16", {48'd0, res_a16}, 64'd0);
        chk("rst_flags", {52'd0, done, busy, ovf, rdy}, 64'd0);

        // IN_VALID in IDLE must be ignored.
        in_valid = 1'b1; a = 8'hff; b = 8'hff;
        repeat (3) @(posedge clk);
        #1 in_valid = 1'b0;
        chk("idle_ignore", {55'd0, rdy, busy, done}, 64'd0);

        // a=b=255 x8: default 520200; ACC_W=16 overflows.
        for (int i = 0; i < 8; i++) begin va[i] = 8'hff; vb[i] = 8'hff; end
        begin_op(va, vb, 1'b1);
        feed(va, vb, 8, 1'b0, 1'b0);
        chk("t1_result", {44'd0, res_def}, 64'd520200);
        chk("t1_ovf", {63'd0, ovf[0]}, 64'd0);
        chk("t4_result", {48'd0, res_a16}, SAT ? 64'd65535 : 64'd61448);
        chk("t4_ovf", {63'd0, ovf[2]}, 64'd1);
        post_done();

        // a=1..8, b=2 with bubbles
        for (int i = 0; i < 8; i++) begin va[i] = 8'(i + 1); vb[i] = 8'd2; end
        begin_op(va, vb, 1'b1);
        feed(va, vb, 8, 1'b1, 1'b0);
        chk("t2_result", {44'd0, res_def}, 64'd72);
        post_done();

        // signed -128 * 127 x8
        for (int i = 0; i < 8; i++) begin va[i] = 8'h80; vb[i] = 8'h7f; end
        begin_op(va, vb, 1'b1);
        feed(va, vb, 8, 1'b0, 1'b0);
        chk("t3_result", {44'd0, res_sgn}, {44'd0, 20'hE0400});
        chk("t3_ovf", {63'd0, ovf[1]}, 64'd0);
        post_done();

        // random vectors, scoreboard only
        repeat (2) begin
            for (int i = 0; i < 8; i++) begin
                va[i] = 8'($urandom_range(0, 255));
                vb[i] = 8'($urandom_range(0, 255));
            end
            begin_op(va, vb, 1'b1);
            feed(va, vb, 8, 1'b0, 1'b0);
            post_done();
        end

        // reset mid-operation after 3 beats
        for (int i = 0; i < 8; i++) begin va[i] = 8'hff; vb[i] = 8'hff; end
        begin_op(va, vb, 1'b0);
        feed(va, vb, 3, 1'b0, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("t5_rst_res_def", {44'd0, res_def}, 64'd0);
        chk("t5_rst_res_a16", {48'd0, res_a16}, 64'd0);
        chk("t5_rst_flags", {52'd0, done, busy, ovf, rdy}, 64'd0);
        for (int i = 0; i < 8; i++) begin va[i] = 8'd1; vb[i] = 8'd1; end
        begin_op(va, vb, 1'b1);
        feed(va, vb, 8, 1'b0, 1'b0);
        chk("t5_result", {44'd0, res_def}, 64'd8);
        post_done();

        // START mid-ACCUM ignored; START in DONE cycle accepted
        for (int i = 0; i < 8; i++) begin va[i] = 8'd2; vb[i] = 8'd3; end
        begin_op(va, vb, 1'b1);
        feed(va, vb, 8, 1'b0, 1'b1);
        chk("t6a_result", {44'd0, res_def}, 64'd48);
        chk("t6a_done", {61'd0, done}, 64'd7);
        begin_op(va, vb, 1'b1);
        feed(va, vb, 8, 1'b0, 1'b0);
        chk("t6b_result", {44'd0, res_def}, 64'd48);
        post_done();

        repeat (2) @(posedge clk);
        #1 chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
